border_gen_shrink: RTL and testbench

Parametrised, registered successor to the snake playfield border generator. Answers "is (x, y) a wall?" for a GRID_W × GRID_H grid, one cycle after the coordinate is presented. Adds a shrinking-arena mode: on a programmable number of game ticks the wall moves inward by one cell, with a warning flag before each shrink. It sits between the pixel/cell scanner and the collision and draw logic.

---
 rtl/border_gen_shrink_if.sv | 37 +++
 rtl/border_gen_shrink.sv | 110 +++++++++++
 tb/tb_border_gen_shrink.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/border_gen_shrink_if.sv
// border_gen_shrink_if: groups the coordinate query, arena control and
// arena status signals of border_gen_shrink into one bundle.
//   master: drives x, y, mode, tick and clear, and observes the status outputs.
//   slave : the border generator itself.
//   x, y     cell coordinate to test
//   mode     0 = static border, 1 = shrinking arena
//   tick     single-cycle game-step pulse
//   clear    synchronous restart of inset and tick count
//   isBorder registered wall flag for the previous coordinate
//   inset    current shrink level
//   warn     shrink imminent
//   at_max   inset has reached its maximum
interface border_gen_shrink_if #(
    parameter int XW = 4,
    parameter int YW = 4,
    parameter int IW = 3
);
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          mode;
    logic          tick;
    logic          clear;
    logic          isBorder;
    logic [IW-1:0] inset;
    logic          warn;
    logic          at_max;

    modport master (
        output x, y, mode, tick, clear,
        input  isBorder, inset, warn, at_max
    );

    modport slave (
        input  x, y, mode, tick, clear,
        output isBorder, inset, warn, at_max
    );
endinterface

// File: rtl/border_gen_shrink.sv
// border_gen_shrink: registered playfield wall generator with a shrinking
// arena. Answers "is (x, y) a wall?" one cycle after the coordinate is
// presented. In mode 1 the wall moves inward by one cell every
// SHRINK_PERIOD ticks, up to MAX_INSET, with warn raised for the last
// WARN_TICKS ticks before each step.
//   clk   rising-edge system clock
//   nRst  asynchronous active-low reset
//   bus   border_gen_shrink_if slave (x, y, mode, tick, clear in;
//         isBorder, inset, warn, at_max out)
module border_gen_shrink #(
    parameter int GRID_W        = 16,
    parameter int GRID_H        = 12,
    parameter int XW            = 4,
    parameter int YW            = 4,
    parameter int MAX_INSET     = 4,
    parameter int SHRINK_PERIOD = 8,
    parameter int WARN_TICKS    = 2
) (
    input  logic                clk,
    input  logic                nRst,
    border_gen_shrink_if.slave  bus
);
    localparam int IW = $clog2(MAX_INSET + 1);
    localparam int CW = $clog2(SHRINK_PERIOD);
    // One spare bit so GRID-1-k and the range compares never wrap.
    localparam int AW = ((XW > YW) ? XW : YW) + 1;

    typedef enum logic [1:0] {
        S_STATIC = 2'd0,
        S_COUNT  = 2'd1,
        S_WARN   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] inset_q, inset_d;
    logic          border_q, border_d;
    logic          at_max_q;

    logic [AW-1:0] x_e, y_e, k_e, x_lim, y_lim;

    assign at_max_q = (inset_q == IW'(MAX_INSET));

    // Wall test against the inset held before the edge.
    always_comb begin
        x_e      = AW'(bus.x);
        y_e      = AW'(bus.y);
        k_e      = AW'(inset_q);
        x_lim    = AW'(GRID_W - 1) - k_e;
        y_lim    = AW'(GRID_H - 1) - k_e;
        border_d = (x_e >= AW'(GRID_W)) || (y_e >= AW'(GRID_H)) ||
                   (x_e <= k_e) || (x_e >= x_lim) ||
                   (y_e <= k_e) || (y_e >= y_lim);
    end

    // Tick counter and inset; clear outranks tick.
    always_comb begin
        cnt_d   = cnt_q;
        inset_d = inset_q;
        if (bus.clear) begin
            cnt_d   = '0;
            inset_d = '0;
        end else if (at_max_q) begin
            cnt_d = '0;
        end else if (bus.mode && bus.tick) begin
            if (cnt_q == CW'(SHRINK_PERIOD - 1)) begin
                cnt_d   = '0;
                inset_d = inset_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State tracks the post-edge counters so warn is a pure register decode.
    always_comb begin
        state_d = S_STATIC;
        if (inset_d == IW'(MAX_INSET)) begin
            state_d = S_DONE;
        end else if (!bus.mode) begin
            state_d = S_STATIC;
        end else if (cnt_d >= CW'(SHRINK_PERIOD - WARN_TICKS)) begin
            state_d = S_WARN;
        end else begin
            state_d = S_COUNT;
        end
    end

    // Reset lands in STATIC; COUNT would be indistinguishable here since
    // tick_cnt=0 keeps warn low, and the next edge selects by mode.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= S_STATIC;
            cnt_q    <= '0;
            inset_q  <= '0;
            border_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inset_q  <= inset_d;
            border_q <= border_d;
        end
    end

    assign bus.isBorder = border_q;
    assign bus.inset    = inset_q;
    assign bus.warn     = (state_q == S_WARN);
    assign bus.at_max   = at_max_q;
endmodule

// File: tb/tb_border_gen_shrink.sv
// Directed bench for border_gen_shrink: default-parameter instance for the
// wall sweep, shrink cadence, saturation, reset, clear priority and mode
// freeze; a 32x24 instance for the parameter sweep.
module tb_border_gen_shrink;
    logic clk;
    logic nRst;
    int   total;
    int   bad;

    border_gen_shrink_if #(.XW(4), .YW(4), .IW(3)) ifa ();
    border_gen_shrink_if #(.XW(5), .YW(5), .IW(3)) ifb ();

    border_gen_shrink #(
        .GRID_W(16), .GRID_H(12), .XW(4), .YW(4),
        .MAX_INSET(4), .SHRINK_PERIOD(8), .WARN_TICKS(2)
    ) dut_a (
        .clk(clk), .nRst(nRst), .bus(ifa)
    );

    border_gen_shrink #(
        .GRID_W(32), .GRID_H(24), .XW(5), .YW(5),
        .MAX_INSET(6), .SHRINK_PERIOD(8), .WARN_TICKS(2)
    ) dut_b (
        .clk(clk), .nRst(nRst), .bus(ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_a();
        ifa.tick = 1'b1;
        step();
        ifa.tick = 1'b0;
    endtask

    task automatic tick_b();
        ifb.tick = 1'b1;
        step();
        ifb.tick = 1'b0;
    endtask

    task automatic probe_a(input int px, input int py, input int exp, input string tag);
        ifa.x = 4'(px);
        ifa.y = 4'(py);
        step();
        chk(tag, int'(ifa.isBorder), exp);
    endtask

    task automatic probe_b(input int px, input int py, input int exp, input string tag);
        ifb.x = 5'(px);
        ifb.y = 5'(py);
        step();
        chk(tag, int'(ifb.isBorder), exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        ifa.x = '0; ifa.y = '0; ifa.mode = 1'b0; ifa.tick = 1'b0; ifa.clear = 1'b0;
        ifb.x = '0; ifb.y = '0; ifb.mode = 1'b0; ifb.tick = 1'b0; ifb.clear = 1'b0;
        nRst  = 1'b1;
        #2 nRst = 1'b0;
        #1;
        chk("rst_isBorder", int'(ifa.isBorder), 0);
        chk("rst_inset",    int'(ifa.inset),    0);
        chk("rst_warn",     int'(ifa.warn),     0);
        chk("rst_at_max",   int'(ifa.at_max),   0);
        step();
        step();
        #3 nRst = 1'b1;
        step();

        // Static sweep, mode 0, inset 0: wall at x in {0,15} or y in {0,11}.
        for (int yi = 0; yi < 12; yi++) begin
            for (int xi = 0; xi < 16; xi++) begin
                probe_a(xi, yi, (xi == 0 || xi == 15 || yi == 0 || yi == 11) ? 1 : 0, "static_sweep");
            end
        end

        probe_a(15, 12, 1, "oor_y12");
        probe_a(0, 15, 1, "oor_y15");

        // Shrink cadence.
        ifa.mode = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) begin
            tick_a();
            if (i <= 5) chk("cad_warn_low", int'(ifa.warn), 0);
            if (i == 6 || i == 7) chk("cad_warn_high", int'(ifa.warn), 1);
            if (i == 7) chk("cad_inset0", int'(ifa.inset), 0);
        end
        chk("cad_inset1", int'(ifa.inset), 1);
        chk("cad_warn_off", int'(ifa.warn), 0);
        probe_a(1, 5, 1, "cad_wall_1_5");
        probe_a(2, 5, 0, "cad_open_2_5");
        probe_a(14, 5, 1, "cad_wall_14_5");
        probe_a(13, 5, 0, "cad_open_13_5");

        // Saturation from a cleared arena.
        ifa.clear = 1'b1;
        step();
        ifa.clear = 1'b0;
        chk("clr_inset", int'(ifa.inset), 0);
        for (int i = 1; i <= 40; i++) begin
            tick_a();
            if (i == 31) begin
                chk("sat_inset3",  int'(ifa.inset),  3);
                chk("sat_atmax0",  int'(ifa.at_max), 0);
            end
            if (i == 32) begin
                chk("sat_inset4",  int'(ifa.inset),  4);
                chk("sat_atmax1",  int'(ifa.at_max), 1);
                chk("sat_warn32",  int'(ifa.warn),   0);
            end
            if (i == 38) chk("sat_warn38", int'(ifa.warn), 0);
        end
        chk("sat_inset40", int'(ifa.inset), 4);
        chk("sat_warn40",  int'(ifa.warn),  0);
        // k=4: wall for x<=4, x>=11, y<=4, y>=7.
        probe_a(4, 5, 1, "sat_wall_4_5");
        probe_a(5, 5, 0, "sat_open_5_5");
        probe_a(6, 5, 0, "sat_open_6_5");
        probe_a(10, 6, 0, "sat_open_10_6");
        probe_a(11, 5, 1, "sat_wall_11_5");
        probe_a(5, 7, 1, "sat_wall_5_7");
        probe_a(5, 4, 1, "sat_wall_5_4");

        // Asynchronous reset mid-cycle while at maximum inset.
        probe_a(0, 0, 1, "pre_rst_wall");
        #3 nRst = 1'b0;
        #1;
        chk("arst_isBorder", int'(ifa.isBorder), 0);
        chk("arst_inset",    int'(ifa.inset),    0);
        chk("arst_warn",     int'(ifa.warn),     0);
        chk("arst_at_max",   int'(ifa.at_max),   0);
        nRst = 1'b1;
        step();

        // Clear and tick together at tick_cnt=7: tick is dropped.
        for (int i = 0; i < 7; i++) tick_a();
        chk("pri_warn_cnt7", int'(ifa.warn), 1);
        ifa.clear = 1'b1;
        ifa.tick  = 1'b1;
        step();
        ifa.clear = 1'b0;
        ifa.tick  = 1'b0;
        chk("pri_inset", int'(ifa.inset), 0);
        chk("pri_warn",  int'(ifa.warn),  0);
        for (int i = 1; i <= 6; i++) begin
            tick_a();
            if (i == 5) chk("pri_cnt5_warn", int'(ifa.warn), 0);
        end
        chk("pri_cnt6_warn", int'(ifa.warn), 1);
        tick_a();
        tick_a();
        chk("pri_inset1", int'(ifa.inset), 1);

        // Mode freeze at tick_cnt=3.
        ifa.clear = 1'b1;
        step();
        ifa.clear = 1'b0;
        for (int i = 0; i < 3; i++) tick_a();
        ifa.mode = 1'b0;
        step();
        for (int i = 0; i < 5; i++) tick_a();
        chk("frz_inset", int'(ifa.inset), 0);
        chk("frz_warn",  int'(ifa.warn),  0);
        ifa.mode = 1'b1;
        step();
        tick_a();
        tick_a();
        chk("frz_cnt5_warn", int'(ifa.warn), 0);
        tick_a();
        chk("frz_cnt6_warn", int'(ifa.warn), 1);
        chk("frz_inset_kept", int'(ifa.inset), 0);

        // Parameter sweep instance: 32x24, MAX_INSET 6.
        probe_b(31, 10, 1, "p_wall_31_10");
        probe_b(30, 10, 0, "p_open_30_10");
        probe_b(10, 23, 1, "p_wall_10_23");
        ifb.mode = 1'b1;
        step();
        for (int i = 1; i <= 48; i++) begin
            tick_b();
            if (i == 47) chk("p_atmax0", int'(ifb.at_max), 0);
        end
        chk("p_inset6", int'(ifb.inset),  6);
        chk("p_atmax1", int'(ifb.at_max), 1);
        probe_b(25, 10, 1, "p_wall_25_10");
        probe_b(24, 10, 0, "p_open_24_10");
        probe_b(10, 17, 1, "p_wall_10_17");
        probe_b(10, 16, 0, "p_open_10_16");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
